// File: rtl/vga_demo_sequencer.sv
// Startup and mode sequencer for the VGA demo core: gates core reset on a qualified PLL lock, then steps the display mode at frame boundaries.
// Outputs are registered; lock loss reaches core_rst_n 3 edges after pll_locked falls; no backpressure (free-running control block).
module vga_demo_sequencer #(
    parameter int LOCK_CYCLES     = 1024,
    parameter int RESET_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FRAMES_PER_MODE = 300,
    parameter int NUM_MODES       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       btn_n,
    input  logic       vsync,
    output logic       core_rst_n,
    output logic [7:0] ui_cfg,
    output logic       run
);

    localparam int LW = (LOCK_CYCLES > 1)     ? $clog2(LOCK_CYCLES)     : 1;
    localparam int HW = (RESET_CYCLES > 1)    ? $clog2(RESET_CYCLES)    : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = (FRAMES_PER_MODE > 0) ? FW'(FRAMES_PER_MODE - 1) : '0;
    localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);
    localparam bit            AUTO_EN   = (FRAMES_PER_MODE != 0);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            core_rst_n_nxt;
    logic            run_nxt;

    logic [1:0]      lock_sync;
    logic [1:0]      btn_sync;
    logic            lock_s;
    logic            btn_s;

    logic [LW-1:0]   lock_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [DW-1:0]   db_cnt;
    logic [FW-1:0]   fcnt;

    logic            btn_db;
    logic            btn_db_q;
    logic            press;
    logic            vsync_q;
    logic            tick;
    logic            pend;
    logic            auto_hit;
    logic            adv;
    logic [2:0]      mode;
    logic [2:0]      mode_inc;

    // Two-flop synchronizers; the button idles high so its flops reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync <= 2'b00;
            btn_sync  <= 2'b11;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked};
            btn_sync  <= {btn_sync[0], btn_n};
        end
    end

    assign lock_s = lock_sync[1];
    assign btn_s  = btn_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            core_rst_n <= 1'b0;
            run        <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_rst_n <= core_rst_n_nxt;
            run        <= run_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!lock_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK:  if (lock_cnt == LOCK_LAST) state_nxt = RESET_HOLD;
                RESET_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
                RUN:        state_nxt = RUN;
                default:    state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        core_rst_n_nxt = 1'b0;
        run_nxt        = 1'b0;
        if (state_nxt == RUN) begin
            core_rst_n_nxt = 1'b1;
            run_nxt        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if (state == WAIT_LOCK && lock_s && lock_cnt != LOCK_LAST)
                lock_cnt <= lock_cnt + 1'b1;
            else
                lock_cnt <= '0;

            if (state == RESET_HOLD && lock_s && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

    // Debounce: accept a new level only after it has differed from btn_db for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b1;
            btn_db_q <= 1'b1;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press    = btn_db_q & ~btn_db;
    assign tick     = vsync_q & ~vsync;
    assign auto_hit = AUTO_EN && (fcnt == FCNT_LAST);
    assign adv      = pend | auto_hit;
    assign mode_inc = (mode == MODE_LAST) ? 3'd0 : mode + 3'd1;

    // A press on the tick edge re-arms pend after the clear, so it lands on the following tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            mode    <= 3'd0;
            pend    <= 1'b0;
            fcnt    <= '0;
        end else begin
            vsync_q <= vsync;
            if (!lock_s) begin
                pend <= 1'b0;
                fcnt <= '0;
            end else if (state == RUN) begin
                if (tick) begin
                    if (adv) begin
                        mode <= mode_inc;
                        fcnt <= '0;
                        pend <= 1'b0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                if (press)
                    pend <= 1'b1;
            end
        end
    end

    assign ui_cfg = {5'b00000, mode};

endmodule

// File: tb/tb_vga_demo_sequencer.sv
// Directed bench for vga_demo_sequencer with short lock/hold/debounce limits and a 20-high/2-low synthetic vsync.
module tb_vga_demo_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       btn_n;
    logic       vsync;
    logic       core_rst_n;
    logic [7:0] ui_cfg;
    logic       run;

    int         n_vec;
    int         n_miss;
    logic [7:0] exp_cfg;
    logic [7:0] auto_tab [9];

    vga_demo_sequencer #(
        .LOCK_CYCLES     (8),
        .RESET_CYCLES    (4),
        .DEBOUNCE_CYCLES (4),
        .FRAMES_PER_MODE (3),
        .NUM_MODES       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .btn_n      (btn_n),
        .vsync      (vsync),
        .core_rst_n (core_rst_n),
        .ui_cfg     (ui_cfg),
        .run        (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hi(input int n);
        vsync = 1'b1;
        repeat (n) step();
    endtask

    // One vsync low pulse: cfg must be unchanged before the fall and hold nxt right after the tick edge.
    task automatic fall(input logic [7:0] nxt, input string tag);
        check({tag, "_pre"}, {24'd0, ui_cfg}, {24'd0, exp_cfg});
        vsync = 1'b0;
        step();
        check(tag, {24'd0, ui_cfg}, {24'd0, nxt});
        step();
        vsync   = 1'b1;
        exp_cfg = nxt;
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        exp_cfg    = 8'h00;
        auto_tab   = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd0};
        rst        = 1'b1;
        pll_locked = 1'b1;
        btn_n      = 1'b1;
        vsync      = 1'b1;
        repeat (3) step();
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_ui_cfg", {24'd0, ui_cfg}, 32'd0);

        // Startup: release at edge 2+8+4 = 14.
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            check($sformatf("start_core_rst_n_e%0d", e), {31'd0, core_rst_n}, (e >= 14) ? 32'd1 : 32'd0);
            check($sformatf("start_run_e%0d", e), {31'd0, run}, (e >= 14) ? 32'd1 : 32'd0);
        end
        check("start_ui_cfg", {24'd0, ui_cfg}, 32'd0);

        // Mid-run reset, then a one-cycle lock glitch while counting.
        rst = 1'b1;
        step();
        check("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("midrst_run", {31'd0, run}, 32'd0);
        rst = 1'b0;
        repeat (8) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("glitch_core_rst_n_k%0d", k), {31'd0, core_rst_n}, (k >= 14) ? 32'd1 : 32'd0);
        end

        // Auto-advance over nine frames with wrap.
        for (int i = 0; i < 9; i++) begin
            hi(20);
            fall(auto_tab[i], $sformatf("auto_f%0d", i + 1));
        end

        // Bouncy button then a solid hold: one step on the next tick.
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0;
            hi(2);
            btn_n = 1'b1;
            hi(2);
        end
        btn_n = 1'b0;
        hi(8);
        fall(8'd1, "bounce");
        btn_n = 1'b1;
        hi(20);
        fall(8'd1, "bounce_once");

        // Two clean presses in one frame collapse; frame count restarts after the step.
        btn_n = 1'b0;
        hi(6);
        btn_n = 1'b1;
        hi(6);
        btn_n = 1'b0;
        hi(6);
        btn_n = 1'b1;
        hi(2);
        fall(8'd2, "two_press");
        hi(20);
        fall(8'd2, "fcnt_rst1");
        hi(20);
        fall(8'd2, "fcnt_rst2");

        // Press pending on the tick where the frame count is also due: single step 2 -> 0.
        btn_n = 1'b0;
        hi(6);
        btn_n = 1'b1;
        hi(14);
        fall(8'd0, "simul");

        // Press recognised on the tick edge itself waits for the following tick.
        hi(14);
        btn_n = 1'b0;
        hi(6);
        fall(8'd0, "press_on_tick");
        btn_n = 1'b1;
        hi(20);
        fall(8'd1, "press_late");
        btn_n = 1'b0;
        hi(6);
        btn_n = 1'b1;
        hi(14);
        fall(8'd2, "press_to2");

        // Lock loss in RUN at mode 2.
        pll_locked = 1'b0;
        step();
        step();
        check("loss_e2_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        step();
        check("loss_e3_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("loss_e3_run", {31'd0, run}, 32'd0);
        btn_n = 1'b0;
        hi(6);
        btn_n = 1'b1;
        hi(14);
        fall(8'd2, "loss_tick");

        pll_locked = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("relock_core_rst_n_k%0d", k), {31'd0, core_rst_n}, (k >= 14) ? 32'd1 : 32'd0);
        end
        check("relock_ui_cfg", {24'd0, ui_cfg}, 32'd2);
        hi(20);
        fall(8'd2, "relock_tick");

        // Synchronous reset clears the mode.
        rst = 1'b1;
        step();
        check("final_rst_ui_cfg", {24'd0, ui_cfg}, 32'd0);
        check("final_rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("final_rst_run", {31'd0, run}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ui_cfg", {24'd0, ui_cfg}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_demo_sequencer.md
# vga_demo_sequencer

Startup and mode controller for the VGA demo core on the FPGA build. It holds the core in reset until the 25.175 MHz PLL has been stably locked, then releases it. It then steps the core's display mode (driven on `ui_in`), either automatically every N frames or on a debounced button press. Mode changes are applied only at frame boundaries, which are detected from the core's own vsync output.

## Interface

Parameters:
- `LOCK_CYCLES`, default 1024: consecutive synchronized-lock cycles required before leaving WAIT_LOCK.
- `RESET_CYCLES`, default 16: cycles the core reset is held after lock qualifies.
- `DEBOUNCE_CYCLES`, default 250000: cycles a button level must be stable to be accepted (about 10 ms).
- `FRAMES_PER_MODE`, default 300: frames per mode under auto-advance. A value of 0 disables auto-advance.
- `NUM_MODES`, default 4: number of modes. Legal range is 1..8.

Ports:
- `clk` in 1: 25.175 MHz pixel clock (PLL output). This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock flag. Asynchronous; synchronized internally.
- `btn_n` in 1: raw mode button, active low. Asynchronous; synchronized internally.
- `vsync` in 1: the core's vsync output (`uo_out[3]`), active low, in the `clk` domain.
- `core_rst_n` out 1: registered active-low reset to the demo core.
- `ui_cfg` out 8: registered configuration to the core's `ui_in`, equal to `{5'b0, mode[2:0]}`.
- `run` out 1: registered; high only in RUN. Drives the status LED.

## Operation

- Synchronizers: `pll_locked` and `btn_n` each pass through 2 flops, giving `lock_s` and `btn_s`.
- State machine, with states WAIT_LOCK, RESET_HOLD and RUN:
  - WAIT_LOCK:
    - `lock_cnt` increments each cycle while `lock_s`=1 and clears to 0 on `lock_s`=0.
    - When `lock_s`=1 and `lock_cnt`==LOCK_CYCLES-1, go to RESET_HOLD.
  - RESET_HOLD:
    - `hold_cnt` counts 0..RESET_CYCLES-1.
    - On the last count, go to RUN.
  - RUN: stays in RUN.
  - From any state, `lock_s`=0 sends the FSM to WAIT_LOCK on the next edge. Counters, the pending request and the frame counter are cleared.
  - `mode` is retained across lock loss and is cleared only by `rst`.
- Outputs by state:
  - `core_rst_n`=0 in WAIT_LOCK and RESET_HOLD; 1 in RUN.
  - `run` follows the same pattern as `core_rst_n`.
  - These outputs are registered with the state, so they change on the same edge as the state.
- Debounce:
  - `btn_db` (reset value 1) takes the value of `btn_s` after `btn_s`≠`btn_db` has held for DEBOUNCE_CYCLES consecutive cycles.
  - The stability counter clears whenever `btn_s`==`btn_db`.
  - A press is a 1→0 transition of `btn_db`. It sets `pend`, but only in RUN; presses in other states are dropped.
- Frame tick:
  - `vsync_q` <= `vsync`.
  - `tick` = `vsync_q` & ~`vsync`, i.e. the falling edge of vsync.
  - `tick` is acted on only in RUN.
- Frame counter and mode advance, on `tick` in RUN:
  - Advance when `pend`=1, or when FRAMES_PER_MODE≠0 and `fcnt`==FRAMES_PER_MODE-1.
  - Advance: `mode` <= (`mode`==NUM_MODES-1) ? 0 : `mode`+1. Also `fcnt` <= 0 and `pend` <= 0.
  - No advance: `fcnt` <= `fcnt`+1.
  - At most one step per tick, even when a button request and the auto-advance condition coincide.
  - A press arriving on the same cycle as the tick takes effect at the next tick.
  - Multiple presses within one frame collapse to one step.
- Widths:
  - `lock_cnt`, `hold_cnt`, `fcnt` and the debounce counter are $clog2 of their limit, with a minimum of 1 bit.
  - `mode` is 3 bits.
  - With NUM_MODES=1, `mode` stays 0.

## Timing

- Reset values: state=WAIT_LOCK, `core_rst_n`=0, `run`=0, `ui_cfg`=8'h00, `mode`=0, `pend`=0, `fcnt`=0, `btn_db`=1, `vsync_q`=1, all counters 0, synchronizer flops 0 (lock) and 1 (button).
- `rst` is honored mid-operation: on the next edge everything returns to the reset values above.
- Startup latency, with `pll_locked` high from the first post-reset edge:
  - RESET_HOLD is entered at edge 2+LOCK_CYCLES.
  - `core_rst_n` and `run` go to 1 at edge 2+LOCK_CYCLES+RESET_CYCLES.
- `ui_cfg` updates on the edge at which `tick` is seen, which is the first edge after vsync falls. The change therefore lands in vertical blanking.
- Lock loss: `core_rst_n` drops 3 edges after `pll_locked` falls (2 synchronizer edges plus 1 state edge).
- Button latency: a clean press reaches `pend` 2+DEBOUNCE_CYCLES+1 edges after `btn_n` falls.

## Test plan

Bench parameters: LOCK_CYCLES=8, RESET_CYCLES=4, DEBOUNCE_CYCLES=4, FRAMES_PER_MODE=3, NUM_MODES=3. Synthetic vsync: 20 cycles high, 2 cycles low.

- Startup: release `rst` with `pll_locked`=1 → `core_rst_n` and `run` are 0 through edge 13 and 1 at edge 14; `ui_cfg`=0.
- Lock glitch: `pll_locked` drops for 1 cycle at cycle 6 of counting → the lock count restarts, and `core_rst_n` rises exactly 2+8+4 edges after lock returns.
- Auto-advance with wrap: run 9 frames with no button → `ui_cfg` steps 0→1→2→0 on ticks 3, 6 and 9, each one edge after vsync falls.
- Bounce and collapse:
  - Toggle `btn_n` every 2 cycles, then hold it low → exactly 1 step, at the next tick.
  - Two clean presses in one frame → 1 step, and `fcnt` restarts.
- Simultaneous events: `pend`=1 on the tick where `fcnt`==2 → `mode` advances by 1, not 2.
- Lock loss in RUN at `mode`=2:
  - `core_rst_n`=0 three edges after the drop.
  - Ticks and presses are ignored while the lock is low.
  - On relock, `core_rst_n` returns and `ui_cfg` still equals 2.
  - Asserting `rst` instead returns `ui_cfg` to 0.
